// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   mode_e   - pattern modes selected by the 3-bit switch input
//   dir_e    - ping-pong travel direction
//   init_led - value loaded into the LED register when a mode is entered
package led_seq_pkg;

    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_ON       = 3'd1,
        MODE_ROTL     = 3'd2,
        MODE_ROTR     = 3'd3,
        MODE_PINGPONG = 3'd4,
        MODE_COUNT    = 3'd5,
        MODE_BLINK    = 3'd6,
        MODE_FILL     = 3'd7
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] LED_ALL_OFF = 8'h00;
    localparam logic [7:0] LED_ALL_ON  = 8'hFF;
    localparam logic [7:0] LED_LSB     = 8'h01;
    localparam logic [7:0] LED_MSB     = 8'h80;
    localparam logic [7:0] LED_BLINK_A = 8'h55;

    function automatic logic [7:0] init_led(input mode_e m);
        logic [7:0] v;
        case (m)
            MODE_OFF:      v = LED_ALL_OFF;
            MODE_ON:       v = LED_ALL_ON;
            MODE_ROTL:     v = LED_LSB;
            MODE_ROTR:     v = LED_MSB;
            MODE_PINGPONG: v = LED_LSB;
            MODE_COUNT:    v = LED_ALL_OFF;
            MODE_BLINK:    v = LED_BLINK_A;
            MODE_FILL:     v = LED_ALL_OFF;
            default:       v = LED_ALL_OFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Prescaler for the pattern sequencer. Counts enabled cycles 0..TICK_DIV-1
// and flags the cycle in which the count sits at its last value.
// Ports:
//   clk    - clock, all updates on rising edge
//   rst    - synchronous active-high reset
//   enable - count advances only while high, holds otherwise
//   clear  - synchronous restart of the count at 0 (wins over enable)
//   tick   - combinational: enable high and count at TICK_DIV-1
module led_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable & at_last;

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Drives an 8-bit LED bank with one of eight patterns chosen by switch.
// The pattern advances once every TICK_DIV enabled cycles.
// Ports:
//   clk    - clock, all updates on rising edge
//   rst    - synchronous active-high reset
//   enable - high: prescaler and pattern advance; low: everything holds
//   switch - pattern mode select, compared against the held mode every cycle
//   led    - current pattern (register output)
//   step   - one-cycle pulse while led shows a freshly stepped value
//
// state (mode) | meaning
// OFF          | led fixed at 0x00
// ON           | led fixed at 0xFF
// ROTL         | single lit bit rotating left
// ROTR         | single lit bit rotating right
// PINGPONG     | single lit bit bouncing between bit 0 and bit 7
// COUNT        | binary up-counter, wraps 0xFF -> 0x00
// BLINK        | alternates 0x55 / 0xAA
// FILL         | fills with ones from bit 0, then clears to 0x00
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] switch,
    output logic [7:0] led,
    output logic       step
);

    mode_e      mode_q, mode_d;
    dir_e       dir_q,  dir_d;
    logic [7:0] led_q,  led_d;
    logic       step_q, step_d;

    mode_e      sw_mode;
    logic       mode_chg;
    logic       tick;
    logic       step_ev;
    logic [7:0] led_nxt;
    dir_e       dir_nxt;

    assign sw_mode  = mode_e'(switch);
    assign mode_chg = (sw_mode != mode_q);
    // A mode change restarts the prescaler and suppresses any step due
    // in the same cycle.
    assign step_ev  = tick & ~mode_chg;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (mode_chg),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            dir_q  <= DIR_LEFT;
            led_q  <= LED_ALL_OFF;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    // Next pattern value for the held mode
    always_comb begin
        led_nxt = led_q;
        dir_nxt = dir_q;
        case (mode_q)
            MODE_OFF:  led_nxt = LED_ALL_OFF;
            MODE_ON:   led_nxt = LED_ALL_ON;
            MODE_ROTL: led_nxt = {led_q[6:0], led_q[7]};
            MODE_ROTR: led_nxt = {led_q[0], led_q[7:1]};
            MODE_PINGPONG: begin
                // Direction flips at the ends so each end is shown only once.
                if (dir_q == DIR_LEFT) begin
                    if (led_q == LED_MSB) begin
                        led_nxt = 8'h40;
                        dir_nxt = DIR_RIGHT;
                    end else begin
                        led_nxt = {led_q[6:0], 1'b0};
                    end
                end else begin
                    if (led_q == LED_LSB) begin
                        led_nxt = 8'h02;
                        dir_nxt = DIR_LEFT;
                    end else begin
                        led_nxt = {1'b0, led_q[7:1]};
                    end
                end
            end
            MODE_COUNT: led_nxt = led_q + 8'd1;
            MODE_BLINK: led_nxt = ~led_q;
            MODE_FILL:  led_nxt = (led_q == LED_ALL_ON) ? LED_ALL_OFF
                                                        : {led_q[6:0], 1'b1};
            default:    led_nxt = LED_ALL_OFF;
        endcase
    end

    // Next-state selection: mode change > step > hold
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = 1'b0;
        if (mode_chg) begin
            mode_d = sw_mode;
            dir_d  = DIR_LEFT;
            led_d  = init_led(sw_mode);
        end else if (step_ev) begin
            dir_d  = dir_nxt;
            led_d  = led_nxt;
            step_d = 1'b1;
        end
    end

    // Outputs straight from registers
    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst4 = 1'b1, en4 = 1'b0;
    logic [2:0] sw4 = 3'd0;
    logic [7:0] led4;
    logic       step4;
    logic       rst1 = 1'b1, en1 = 1'b0;
    logic [2:0] sw1 = 3'd0;
    logic [7:0] led1;
    logic       step1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .enable(en4), .switch(sw4), .led(led4), .step(step4)
    );

    led_pattern_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1), .switch(sw1), .led(led1), .step(step1)
    );

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0] rotl_tab [8];
    logic [7:0] ping_tab [15];
    logic [7:0] fill_tab [10];

    initial begin
        rotl_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        ping_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fill_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                     8'hFF, 8'h00, 8'h01};

        // Reset for two cycles, switch=0
        for (int i = 0; i < 2; i++) begin
            edge1();
            chk("rst_led4", led4, 8'h00);
            chk("rst_step4", {7'd0, step4}, 8'h00);
            chk("rst_led1", led1, 8'h00);
        end
        rst4 = 1'b0; en4 = 1'b1;
        rst1 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 5; i++) edge1();
        chk("off_led4", led4, 8'h00);
        chk("off_led1", led1, 8'h00);

        // ROTL with TICK_DIV=4, starting from reset
        rst4 = 1'b1; sw4 = 3'd2;
        edge1();
        chk("rotl_rst", led4, 8'h00);
        rst4 = 1'b0;
        edge1();
        chk("rotl_load", led4, 8'h01);
        chk("rotl_load_step", {7'd0, step4}, 8'h00);
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 3; c++) begin
                edge1();
                chk("rotl_wait_step", {7'd0, step4}, 8'h00);
            end
            chk("rotl_hold", led4, (s == 0) ? 8'h01 : rotl_tab[s-1]);
            edge1();
            chk("rotl_led", led4, rotl_tab[s]);
            chk("rotl_step", {7'd0, step4}, 8'h01);
        end

        // PINGPONG with TICK_DIV=1
        rst1 = 1'b1; sw1 = 3'd4;
        edge1();
        rst1 = 1'b0;
        edge1();
        chk("ping_load", led1, 8'h01);
        chk("ping_load_step", {7'd0, step1}, 8'h00);
        for (int s = 0; s < 15; s++) begin
            edge1();
            chk("ping_led", led1, ping_tab[s]);
            chk("ping_step", {7'd0, step1}, 8'h01);
        end

        // COUNT for 257 steps
        sw1 = 3'd5;
        edge1();
        chk("cnt_load", led1, 8'h00);
        chk("cnt_load_step", {7'd0, step1}, 8'h00);
        for (int k = 1; k <= 257; k++) begin
            edge1();
            if (k == 1)   chk("cnt_1", led1, 8'h01);
            if (k == 255) chk("cnt_255", led1, 8'hFF);
            if (k == 256) chk("cnt_wrap", led1, 8'h00);
            if (k == 257) chk("cnt_257", led1, 8'h01);
        end

        // FILL
        sw1 = 3'd7;
        edge1();
        chk("fill_load", led1, 8'h00);
        for (int s = 0; s < 10; s++) begin
            edge1();
            chk("fill_led", led1, fill_tab[s]);
        end

        // BLINK then mid-count switch to ROTR while frozen
        sw4 = 3'd6;
        edge1();
        chk("blink_load", led4, 8'h55);
        for (int c = 0; c < 3; c++) edge1();
        chk("blink_hold", led4, 8'h55);
        edge1();
        chk("blink_inv", led4, 8'hAA);
        chk("blink_step", {7'd0, step4}, 8'h01);
        edge1();
        edge1();
        en4 = 1'b0; sw4 = 3'd3;
        edge1();
        chk("rotr_load", led4, 8'h80);
        chk("rotr_load_step", {7'd0, step4}, 8'h00);
        for (int c = 0; c < 3; c++) begin
            edge1();
            chk("frz_led", led4, 8'h80);
            chk("frz_step", {7'd0, step4}, 8'h00);
        end
        en4 = 1'b1;
        for (int c = 0; c < 3; c++) edge1();
        chk("rotr_pre", led4, 8'h80);
        chk("rotr_pre_step", {7'd0, step4}, 8'h00);
        edge1();
        chk("rotr_first", led4, 8'h40);
        chk("rotr_first_step", {7'd0, step4}, 8'h01);

        // Reset in the middle of COUNT at 0x2A
        sw1 = 3'd5;
        edge1();
        chk("cnt2_load", led1, 8'h00);
        for (int k = 0; k < 42; k++) edge1();
        chk("cnt2_2a", led1, 8'h2A);
        rst1 = 1'b1;
        edge1();
        chk("mid_rst_led", led1, 8'h00);
        chk("mid_rst_step", {7'd0, step1}, 8'h00);
        rst1 = 1'b0;
        edge1();
        chk("post_rst_load", led1, 8'h00);
        chk("post_rst_step", {7'd0, step1}, 8'h00);
        edge1();
        chk("post_rst_1", led1, 8'h01);
        chk("post_rst_1_step", {7'd0, step1}, 8'h01);
        edge1();
        chk("post_rst_2", led1, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clock cycles per pattern step; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  input  1  run/freeze control; high = pattern advances, low = prescaler and pattern hold.
REQ-005 SHALL have port switch  input  3  pattern mode select, sampled every cycle.
REQ-006 SHALL have port led  output  8  current pattern, driven directly from a register.
REQ-007 SHALL have port step  output  1  registered pulse, high for exactly the one cycle in which led shows a newly stepped value.

Function
REQ-008 SHALL hold a registered mode (3 bit), prescaler count cnt (0..TICK_DIV-1), direction flag dir (LEFT/RIGHT), and the led register.
REQ-009 SHALL give each mode an initial led value: 0 OFF 0x00; 1 ON 0xFF; 2 ROTL 0x01; 3 ROTR 0x80; 4 PINGPONG 0x01, dir=LEFT; 5 COUNT 0x00; 6 BLINK 0x55; 7 FILL 0x00.
REQ-010 SHALL detect a mode change whenever switch differs from the registered mode, regardless of enable.
REQ-011 On a mode change, the next edge SHALL load mode<=switch, led<=initial value of switch, cnt<=0, dir<=LEFT, step<=0.
REQ-012 With no mode change and enable=1, cnt SHALL increment each cycle and wrap to 0 after reaching TICK_DIV-1.
REQ-013 A step SHALL occur on the edge at which enable=1, cnt==TICK_DIV-1 and no mode change occurs; led SHALL take its next value and step SHALL be 1 in the following cycle only.
REQ-014 With TICK_DIV=1, a step SHALL occur on every enabled cycle without a mode change.
REQ-015 Next values SHALL be: OFF stays 0x00; ON stays 0xFF; ROTL rotates left (0x80->0x01); ROTR rotates right (0x01->0x80).
REQ-016 PINGPONG SHALL shift in dir; at 0x80 with dir=LEFT, next=0x40 and dir<=RIGHT; at 0x01 with dir=RIGHT, next=0x02 and dir<=LEFT.
REQ-017 COUNT SHALL add 1 modulo 256 (0xFF->0x00); BLINK SHALL invert led (0x55<->0xAA).
REQ-018 FILL SHALL shift left inserting 1 (0x00,0x01,0x03..0xFF); from 0xFF the next value SHALL be 0x00.
REQ-019 With enable=0 and no mode change, led, cnt, dir and mode SHALL hold, and step SHALL be 0.
REQ-020 Priority SHALL be rst > mode change > step > hold.

Reset
REQ-021 While rst=1 at an edge: led<=0x00, mode<=0 (OFF), cnt<=0, dir<=LEFT, step<=0.
REQ-022 Reset mid-pattern SHALL discard all state; if switch!=0 in the first cycle after release, REQ-011 SHALL apply on the next edge.
REQ-023 No asynchronous reset path SHALL exist.

Structure
REQ-024 Mode enumeration (OFF..FILL), dir encoding and the per-mode initial-value table SHALL live in shared package led_seq_pkg.
REQ-025 The prescaler SHALL be a sub-module led_tick_gen (parameter TICK_DIV; inputs clk, rst, enable, clear; output tick) with counter width $clog2(TICK_DIV) (minimum 1).
REQ-026 Next-pattern logic SHALL be a single combinational case on mode; all outputs registered.

Verification
REQ-027 rst=1 for 2 cycles, switch=0 -> led=0x00, step=0 throughout; after release with enable=1, led stays 0x00.
REQ-028 TICK_DIV=4, switch=2, enable=1 from reset -> led=0x01 one edge after release, then 0x02,0x04 each 4 cycles with one-cycle step pulses; after 0x80 wraps to 0x01.
REQ-029 TICK_DIV=1, switch=4 -> led 0x01,0x02..0x80,0x40..0x01,0x02 on consecutive cycles; step high every cycle after load.
REQ-030 TICK_DIV=1, switch=5 held 257 steps -> led passes 0xFF then 0x00; switch=7 -> 0x00,0x01,0x03..0xFF,0x00.
REQ-031 Mid-count switch change 6->3 with enable=0 -> led=0x80, cnt=0 on next edge, no step pulse; led holds until enable=1, first step after TICK_DIV cycles gives 0x40.
REQ-032 rst=1 asserted while switch=5 and led=0x2A -> led=0x00 next edge; after release led reloads 0x00 (COUNT init) via mode change and counts from 0.
